led_scan_sequencer: RTL and testbench
=====================================

LED_SCAN_SEQUENCER -- requirements
Module: led_scan_sequencer

Interface
REQ-001 Parameter COLS, default 64: columns shifted per scan row (≥2).
REQ-002 Parameter ROWS, default 16: scan rows per frame, a power of two ≥2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  run request; level-sensitive.
REQ-006 fb_addr  output  log2(ROWS)+log2(COLS)  framebuffer read address {row,col}; fixed 1-cycle read latency.
REQ-007 fb_rdata  input  6  pixel pair {R1,G1,B1,R2,G2,B2}.
REQ-008 rgb  output  6  registered shift data to the panel.
REQ-009 sclk  output  1  data shift clock.
REQ-010 row_addr  output  log2(ROWS)  panel row address A..D.
REQ-011 latch_cmd_start, delay_start, oe_enable, oe_disable  output  1 each  single-cycle pulses to the timing controller.
REQ-012 latch_done, delay_done  input  1 each  completion pulses from the timing controller.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse after the last row's display period.

Function
REQ-015 FSM states: IDLE, SH_ADDR, SH_DATA, SH_CLK, LATCH, LATCH_WAIT, BLANK, ROW_SET, DISPLAY.
REQ-016 IDLE -> SH_ADDR when enable=1; col=0.
REQ-017 SH_ADDR: fb_addr={shift_row,col}; sclk=0; next state SH_DATA.
REQ-018 SH_DATA: rgb<=fb_rdata; sclk=0; next state SH_CLK.
REQ-019 SH_CLK: sclk=1; if col=COLS-1 go to LATCH, else col+1 and go to SH_ADDR.
REQ-020 Shifting one row takes exactly 3*COLS cycles; sclk is 0 in every state other than SH_CLK.
REQ-021 LATCH: pulse latch_cmd_start for one cycle; next state LATCH_WAIT.
REQ-022 LATCH_WAIT: hold until latch_done=1; rgb held at 0.
REQ-023 BLANK: pulse oe_disable.
REQ-024 ROW_SET: row_addr<=shift_row, updated in a cycle when no oe_enable pulse has been issued since the last oe_disable pulse.
REQ-025 ROW_SET: pulse oe_enable and delay_start in the same cycle; next state DISPLAY.
REQ-026 DISPLAY: hold until delay_done=1.
REQ-027 DISPLAY exit: shift_row increments and wraps ROWS-1 -> 0.
REQ-028 frame_done pulses on the wrap in the same cycle.
REQ-029 DISPLAY exit, next state: SH_ADDR if enable=1, else IDLE.
REQ-030 enable deasserted mid-row: the current row completes its shift, latch and display; no truncated row.
REQ-031 A latch_done or delay_done pulse is ignored in any state other than its wait state.
REQ-032 Counter widths are exact log2 sizes; col and shift_row never exceed COLS-1 and ROWS-1.

Reset
REQ-033 rst from any state, including mid-shift or a wait state: next state IDLE.
REQ-034 Reset values: col=0, shift_row=0, row_addr=0, rgb=0, sclk=0, fb_addr=0, and all pulse outputs, busy and frame_done =0.
REQ-035 The sequencer issues no oe_disable on reset; the timing controller's own reset disables OE.

Configuration
REQ-036 Macro SCAN_ANTI_GHOST_EN defined: BLANK holds for BLANK_CYCLES (localparam, 4) cycles with OE disabled before ROW_SET.
REQ-037 Macro SCAN_ANTI_GHOST_EN defined: row_addr changes only at the last BLANK cycle.
REQ-038 Macro SCAN_ANTI_GHOST_EN undefined: BLANK lasts one cycle, and row_addr updates in the ROW_SET cycle immediately after the oe_disable pulse.

Structure
REQ-039 Shared package led_panel_pkg holds the FSM state enum, the BLANK_CYCLES constant and the pixel-pair field indices.
REQ-040 The block has no sub-module; the 3-phase shift counter is inline.

Verification
REQ-041 COLS=4, ROWS=2, fb_rdata=addr[5:0], enable=1: four sclk rising edges per row; rgb at each rise = 0,1,2,3 for row 0.
REQ-042 latch_done returned 5 cycles after latch_cmd_start: exactly one latch_cmd_start; oe_disable is not issued before latch_done.
REQ-043 Full frame: row_addr sequence 0,1.
REQ-044 Full frame: frame_done pulses once, in the cycle delay_done ends row 1, and shift_row returns to 0.
REQ-045 enable dropped at col=2 of row 0: row 0 completes its shift, latch and display, then IDLE; busy=0 and no further fb_addr changes.
REQ-046 rst asserted in LATCH_WAIT: the next cycle shows IDLE with all outputs at reset values; a later latch_done is ignored.
REQ-047 SCAN_ANTI_GHOST_EN defined: oe_disable-to-oe_enable spacing = BLANK_CYCLES+1 cycles.
REQ-048 SCAN_ANTI_GHOST_EN undefined: oe_disable-to-oe_enable spacing = 2 cycles.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel scan path: sequencer states, blanking
// length and the bit positions of the two pixels packed in a framebuffer word.
package led_panel_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SH_ADDR,
        SH_DATA,
        SH_CLK,
        LATCH,
        LATCH_WAIT,
        BLANK,
        ROW_SET,
        DISPLAY
    } scan_state_t;

    localparam int BLANK_CYCLES = 4;

    localparam int PIX_W  = 6;
    localparam int PIX_R1 = 5;
    localparam int PIX_G1 = 4;
    localparam int PIX_B1 = 3;
    localparam int PIX_R2 = 2;
    localparam int PIX_G2 = 1;
    localparam int PIX_B2 = 0;

endpackage

// File: rtl/led_scan_sequencer_if.sv
// Pulse handshake between the scan sequencer and the latch/OE timing controller.
interface led_scan_sequencer_if;

    logic latch_cmd_start;
    logic delay_start;
    logic oe_enable;
    logic oe_disable;
    logic latch_done;
    logic delay_done;

    modport master (
        output latch_cmd_start, delay_start, oe_enable, oe_disable,
        input  latch_done, delay_done
    );

    modport slave (
        input  latch_cmd_start, delay_start, oe_enable, oe_disable,
        output latch_done, delay_done
    );

endinterface

// File: rtl/led_scan_sequencer.sv
// Row scan sequencer for a HUB75-style panel: shifts one row, latches, blanks,
// switches the row address and displays. SCAN_ANTI_GHOST_EN stretches blanking.
module led_scan_sequencer
    import led_panel_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 16,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic [ROW_W+COL_W-1:0] fb_addr,
    input  logic [PIX_W-1:0]       fb_rdata,
    output logic [PIX_W-1:0]       rgb,
    output logic                   sclk,
    output logic [ROW_W-1:0]       row_addr,
    output logic                   busy,
    output logic                   frame_done,
    led_scan_sequencer_if.master   tc
);

    scan_state_t      state, state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] shift_row;
    logic             col_last;
    logic             row_last;
    logic             blank_last;

`ifdef SCAN_ANTI_GHOST_EN
    localparam int BLK_W = $clog2(BLANK_CYCLES);
    logic [BLK_W-1:0] blank_cnt;

    assign blank_last = (blank_cnt == BLK_W'(BLANK_CYCLES - 1));
`else
    assign blank_last = 1'b1;
`endif

    assign col_last = (col == COL_W'(COLS - 1));
    assign row_last = (shift_row == ROW_W'(ROWS - 1));
    assign fb_addr  = {shift_row, col};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        sclk               = 1'b0;
        tc.latch_cmd_start = 1'b0;
        tc.delay_start     = 1'b0;
        tc.oe_enable       = 1'b0;
        tc.oe_disable      = 1'b0;
        busy               = (state != IDLE);
        frame_done         = 1'b0;
        case (state)
            IDLE:       if (enable) state_nxt = SH_ADDR;
            SH_ADDR:    state_nxt = SH_DATA;
            SH_DATA:    state_nxt = SH_CLK;
            SH_CLK: begin
                sclk      = 1'b1;
                state_nxt = col_last ? LATCH : SH_ADDR;
            end
            LATCH: begin
                tc.latch_cmd_start = 1'b1;
                state_nxt          = LATCH_WAIT;
            end
            LATCH_WAIT: if (tc.latch_done) state_nxt = BLANK;
            BLANK: begin
`ifdef SCAN_ANTI_GHOST_EN
                tc.oe_disable = (blank_cnt == '0);
`else
                tc.oe_disable = 1'b1;
`endif
                if (blank_last) state_nxt = ROW_SET;
            end
            ROW_SET: begin
                tc.oe_enable   = 1'b1;
                tc.delay_start = 1'b1;
                state_nxt      = DISPLAY;
            end
            DISPLAY: begin
                if (tc.delay_done) begin
                    frame_done = row_last;
                    state_nxt  = enable ? SH_ADDR : IDLE;
                end
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Row address only moves while OE is off: the last blank cycle with
    // anti-ghosting, otherwise the ROW_SET cycle right after oe_disable.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            shift_row <= '0;
            row_addr  <= '0;
            rgb       <= '0;
        end else begin
            case (state)
                IDLE:    col <= '0;
                SH_DATA: rgb <= fb_rdata;
                SH_CLK:  col <= col_last ? '0 : col + COL_W'(1);
                LATCH:   rgb <= '0;
`ifdef SCAN_ANTI_GHOST_EN
                BLANK:   if (blank_last) row_addr <= shift_row;
`else
                ROW_SET: row_addr <= shift_row;
`endif
                DISPLAY: begin
                    if (tc.delay_done)
                        shift_row <= row_last ? '0 : shift_row + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SCAN_ANTI_GHOST_EN
    always_ff @(posedge clk) begin
        if (rst)                         blank_cnt <= '0;
        else if (state == BLANK)         blank_cnt <= blank_last ? '0 : blank_cnt + BLK_W'(1);
        else                             blank_cnt <= '0;
    end
`endif

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer with COLS=4, ROWS=2 and a behavioural
// framebuffer / timing controller.
module tb_led_scan_sequencer;
    import led_panel_pkg::*;

    localparam int COLS      = 4;
    localparam int ROWS      = 2;
    localparam int LATCH_DLY = 5;
    localparam int DELAY_DLY = 3;
`ifdef SCAN_ANTI_GHOST_EN
    localparam int SPAN_EXP  = BLANK_CYCLES + 1;
`else
    localparam int SPAN_EXP  = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] fb_addr;
    logic [5:0] fb_rdata;
    logic [5:0] rgb;
    logic       sclk;
    logic       row_addr;
    logic       busy;
    logic       frame_done;
    logic       resp_en;
    logic       resp_latch;
    logic       resp_delay;
    logic       man_latch;

    led_scan_sequencer_if tc();

    assign tc.latch_done = resp_latch | man_latch;
    assign tc.delay_done = resp_delay;

    led_scan_sequencer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata), .rgb(rgb), .sclk(sclk),
        .row_addr(row_addr), .busy(busy), .frame_done(frame_done), .tc(tc)
    );

    always #5 clk = ~clk;

    // Framebuffer with one-cycle read latency; each word holds its own address.
    always @(posedge clk) fb_rdata <= 6'(fb_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        resp_latch = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (resp_en && tc.latch_cmd_start) begin
                repeat (LATCH_DLY) begin @(posedge clk); #2; end
                resp_latch = 1'b1;
                @(posedge clk); #2;
                resp_latch = 1'b0;
            end
        end
    end

    initial begin
        resp_delay = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (resp_en && tc.delay_start) begin
                repeat (DELAY_DLY) begin @(posedge clk); #2; end
                resp_delay = 1'b1;
                @(posedge clk); #2;
                resp_delay = 1'b0;
            end
        end
    end

    int   cyc = 0;
    logic prev_sclk = 1'b0;
    logic prev_dstart = 1'b0;
    logic latch_pending = 1'b0;
    int   last_dis = 0;
    int   n_latch = 0, n_dis = 0, n_dstart = 0, n_frame = 0;
    int   err_dis_early = 0, err_rgb_wait = 0, pair_err = 0, frame_no_dd = 0;
    int   rise_rgb[$];
    int   rise_cyc[$];
    int   spans[$];
    int   rows_seen[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (tc.oe_disable && latch_pending) err_dis_early++;
            if (latch_pending && rgb != 6'd0) err_rgb_wait++;
            if (sclk && !prev_sclk) begin
                rise_rgb.push_back(int'(rgb));
                rise_cyc.push_back(cyc);
            end
            prev_sclk = sclk;
            if (tc.latch_cmd_start) begin n_latch++; latch_pending = 1'b1; end
            if (tc.latch_done || rst) latch_pending = 1'b0;
            if (tc.oe_disable) begin n_dis++; last_dis = cyc; end
            if (tc.oe_enable) spans.push_back(cyc - last_dis + 1);
            if (tc.oe_enable != tc.delay_start) pair_err++;
            if (prev_dstart) rows_seen.push_back(int'(row_addr));
            prev_dstart = tc.delay_start;
            if (tc.delay_start) n_dstart++;
            if (frame_done) begin
                n_frame++;
                if (!tc.delay_done) frame_no_dd++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    int b_rise, b_latch, b_dstart, b_frame, b_dis, b_span, b_rows;

    initial begin
        rst = 1'b1; enable = 1'b0; resp_en = 1'b1; man_latch = 1'b0;

        // Reset values
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_latch_cmd", tc.latch_cmd_start, 0);
        chk("rst_oe_dis", tc.oe_disable, 0);
        chk("rst_oe_en", tc.oe_enable, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        // Full frame; enable dropped while row 1 is shifting
        b_rise = rise_rgb.size(); b_latch = n_latch; b_frame = n_frame;
        b_span = spans.size(); b_rows = rows_seen.size(); b_dis = n_dis;
        enable = 1'b1;
        for (int i = 0; i < 500 && rise_rgb.size() < b_rise + 5; i++) @(negedge clk);
        enable = 1'b0;
        wait_idle("frame_idle");
        chk("frame_rises", rise_rgb.size() - b_rise, 8);
        for (int i = 0; i < 8 && b_rise + i < rise_rgb.size(); i++)
            chk($sformatf("rgb_rise%0d", i), rise_rgb[b_rise + i], i);
        if (rise_rgb.size() >= b_rise + 4)
            chk("row_shift_span", rise_cyc[b_rise + 3] - rise_cyc[b_rise], 3 * (COLS - 1));
        chk("latch_count", n_latch - b_latch, 2);
        chk("oe_dis_count", n_dis - b_dis, 2);
        chk("oe_dis_early", err_dis_early, 0);
        chk("rgb_in_wait", err_rgb_wait, 0);
        chk("oe_pair", pair_err, 0);
        chk("span_count", spans.size() - b_span, 2);
        for (int i = b_span; i < spans.size(); i++) chk("oe_span", spans[i], SPAN_EXP);
        chk("rows_count", rows_seen.size() - b_rows, 2);
        if (rows_seen.size() >= b_rows + 2) begin
            chk("row_seq0", rows_seen[b_rows], 0);
            chk("row_seq1", rows_seen[b_rows + 1], 1);
        end
        chk("frame_done_cnt", n_frame - b_frame, 1);
        chk("frame_with_dd", frame_no_dd, 0);
        chk("wrap_fb_addr", fb_addr, 0);
        chk("final_row_addr", row_addr, 1);

        // enable dropped at col 2 of row 0
        do_reset();
        b_rise = rise_rgb.size(); b_latch = n_latch; b_dstart = n_dstart; b_frame = n_frame;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 200 && fb_addr != 3'd2; i++) @(negedge clk);
        chk("reach_col2", fb_addr, 2);
        enable = 1'b0;
        wait_idle("drop_idle");
        chk("drop_rises", rise_rgb.size() - b_rise, 4);
        chk("drop_latch", n_latch - b_latch, 1);
        chk("drop_display", n_dstart - b_dstart, 1);
        chk("drop_frame", n_frame - b_frame, 0);
        repeat (20) @(negedge clk);
        chk("drop_busy", busy, 0);
        chk("drop_fb_addr", fb_addr, 4);

        // Reset while waiting for latch_done
        resp_en = 1'b0;
        do_reset();
        b_latch = n_latch;
        enable = 1'b1;
        for (int i = 0; i < 200 && n_latch == b_latch; i++) @(negedge clk);
        chk("reach_latch", n_latch - b_latch, 1);
        repeat (2) @(negedge clk);
        chk("wait_busy", busy, 1);
        enable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wrst_busy", busy, 0);
        chk("wrst_rgb", rgb, 0);
        chk("wrst_sclk", sclk, 0);
        chk("wrst_fb_addr", fb_addr, 0);
        chk("wrst_row_addr", row_addr, 0);
        chk("wrst_pulses", {tc.latch_cmd_start, tc.delay_start, tc.oe_enable, tc.oe_disable, frame_done}, 0);
        rst = 1'b0;
        b_dis = n_dis; b_latch = n_latch;
        @(negedge clk);
        man_latch = 1'b1;
        @(negedge clk);
        man_latch = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_done_busy", busy, 0);
        chk("late_done_oe_dis", n_dis - b_dis, 0);
        chk("late_done_latch", n_latch - b_latch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
